brew_arbiter: RTL and testbench

BREW_ARBITER -- requirements
Module: brew_arbiter

---
 rtl/coffee_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/brew_arbiter.sv | 176 +++++++++++++++++
 tb/tb_brew_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee machine: controller states, default
// stage lengths and the stage-timer width.
package coffee_pkg;

  // Controller states of the shared brew unit.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRIND = 3'd1,
    ST_BREW  = 3'd2,
    ST_MILK  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } brew_state_t;

  // Default number of cycles each actuator stays on per order.
  localparam int DEF_GRIND_CYC = 4;
  localparam int DEF_BREW_CYC  = 8;
  localparam int DEF_MILK_CYC  = 3;

  // Stage timer width; every stage length fits in 1..15.
  localparam int TIMER_W = 4;

  // Timer counts down to zero on the last cycle of a stage, so a stage of
  // n cycles is entered with n-1 loaded.
  function automatic logic [TIMER_W-1:0] stage_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: grants the requesting station closest
// to the pointer, searching upward from the pointer and wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  // Scan from the farthest station to the nearest; the nearest request
  // found last overwrites any earlier candidate, leaving a one-hot grant.
  always_comb begin
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/brew_arbiter.sv
// Shared brew unit controller: picks one order station round-robin and
// sequences grinder, pump and milk valve for it, finishing with a one-cycle
// done or abort pulse. All outputs decode from registered state.
module brew_arbiter
  import coffee_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GRIND_CYC = DEF_GRIND_CYC,
  parameter int BREW_CYC  = DEF_BREW_CYC,
  parameter int MILK_CYC  = DEF_MILK_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             power_on,
  input  logic             milk_present,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] milk_sel,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] abort,
  output logic             grinder_en,
  output logic             pump_en,
  output logic             milk_valve_en,
  output logic             busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TIMER_W-1:0] GRIND_LOAD = stage_load(GRIND_CYC);
  localparam logic [TIMER_W-1:0] BREW_LOAD  = stage_load(BREW_CYC);
  localparam logic [TIMER_W-1:0] MILK_LOAD  = stage_load(MILK_CYC);
  localparam logic [PTR_W-1:0]   LAST_IDX   = PTR_W'(N_REQ - 1);

  brew_state_t        state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [PTR_W-1:0]   ptr_reg,   ptr_next;
  logic [PTR_W-1:0]   idx_reg,   idx_next;
  logic [N_REQ-1:0]   gnt_reg,   gnt_next;
  logic               milk_reg,  milk_next;

  logic [N_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]   arb_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (arb_grant)
  );

  // Convert the one-hot arbiter result into a station index for the pointer.
  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_grant[k]) arb_idx = PTR_W'(k);
    end
  end

  // State, timer, pointer, grant and latched milk choice registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      gnt_reg   <= '0;
      milk_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      gnt_reg   <= gnt_next;
      milk_reg  <= milk_next;
    end
  end

  // Next-state logic: power loss beats every stage transition; the timer
  // reloads on each state entry and only counts down while non-zero.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    gnt_next   = gnt_reg;
    milk_next  = milk_reg;

    case (state_reg)
      ST_IDLE: begin
        if (power_on && (|req)) begin
          state_next = ST_GRIND;
          timer_next = GRIND_LOAD;
          gnt_next   = arb_grant;
          idx_next   = arb_idx;
          milk_next  = |(milk_sel & arb_grant);
        end
      end

      ST_GRIND: begin
        if (!power_on) begin
          state_next = ST_ABORT;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          state_next = ST_BREW;
          timer_next = BREW_LOAD;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      ST_BREW: begin
        if (!power_on) begin
          state_next = ST_ABORT;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          if (!milk_reg) begin
            state_next = ST_DONE;
            timer_next = '0;
          end else if (milk_present) begin
            state_next = ST_MILK;
            timer_next = MILK_LOAD;
          end else begin
            state_next = ST_ABORT;
            timer_next = '0;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      ST_MILK: begin
        if (!power_on || !milk_present) begin
          state_next = ST_ABORT;
          timer_next = '0;
        end else if (timer_reg == '0) begin
          state_next = ST_DONE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      ST_DONE, ST_ABORT: begin
        // Service finished either way: release the grant and hand top
        // priority to the station after the one just served.
        state_next = ST_IDLE;
        timer_next = '0;
        gnt_next   = '0;
        milk_next  = 1'b0;
        ptr_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + PTR_W'(1);
      end

      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
        gnt_next   = '0;
        milk_next  = 1'b0;
      end
    endcase
  end

  // Moore output decode from the registered state and grant.
  always_comb begin
    gnt           = gnt_reg;
    done          = '0;
    abort         = '0;
    grinder_en    = (state_reg == ST_GRIND);
    pump_en       = (state_reg == ST_BREW);
    milk_valve_en = (state_reg == ST_MILK);
    busy          = (state_reg != ST_IDLE);
    if (state_reg == ST_DONE)  done  = gnt_reg;
    if (state_reg == ST_ABORT) abort = gnt_reg;
  end

endmodule

// File: tb/tb_brew_arbiter.sv
// Directed bench for brew_arbiter with default parameters. Inputs change and
// outputs are sampled on the falling edge; cycle n is the period after the
// n-th rising edge following the request being raised in cycle 0.
module tb_brew_arbiter;

  logic       clk;
  logic       reset;
  logic       power_on;
  logic       milk_present;
  logic [3:0] req;
  logic [3:0] milk_sel;
  logic [3:0] gnt;
  logic [3:0] done;
  logic [3:0] abort;
  logic       grinder_en;
  logic       pump_en;
  logic       milk_valve_en;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Observed output vector: {gnt, done, abort, grinder, pump, milk, busy}
  logic [15:0] obs;
  assign obs = {gnt, done, abort, grinder_en, pump_en, milk_valve_en, busy};

  brew_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .power_on      (power_on),
    .milk_present  (milk_present),
    .req           (req),
    .milk_sel      (milk_sel),
    .gnt           (gnt),
    .done          (done),
    .abort         (abort),
    .grinder_en    (grinder_en),
    .pump_en       (pump_en),
    .milk_valve_en (milk_valve_en),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds an expected output vector; busy follows any held grant.
  function automatic logic [15:0] mk(input logic [3:0] g, input logic d, input logic a,
                                     input logic gr, input logic pu, input logic mv);
    return {g, d ? g : 4'b0000, a ? g : 4'b0000, gr, pu, mv, |g};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    req = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, 16'h0000);
    end
    reset = 1'b0;
    req   = 4'b0000;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle c=%0d obs=%b exp=%b", c, obs, 16'h0000);
      end
    end
    $display("reset: released, idle");
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    req = 4'b0001;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = mk((c <= 13) ? 4'b0001 : 4'b0000, c == 13, 1'b0,
               c <= 4, c >= 5 && c <= 12, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 13) req = 4'b0000;
    end
    $display("order: station 0 plain, done expected at cycle 13");
  endtask

  task automatic test_milk();
    logic [15:0] exp;
    req      = 4'b0010;
    milk_sel = 4'b0010;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = mk((c <= 16) ? 4'b0010 : 4'b0000, c == 16, 1'b0,
               c <= 4, c >= 5 && c <= 12, c >= 13 && c <= 15);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL milk c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 16) begin
        req      = 4'b0000;
        milk_sel = 4'b0000;
      end
    end
    $display("order: station 1 milk, done expected at cycle 16");
  endtask

  task automatic test_milk_abort();
    logic [15:0] exp;
    req          = 4'b1000;
    milk_sel     = 4'b1000;
    milk_present = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = mk((c <= 13) ? 4'b1000 : 4'b0000, 1'b0, c == 13,
               c <= 4, c >= 5 && c <= 12, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL milk_abort c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 13) begin
        req          = 4'b0000;
        milk_sel     = 4'b0000;
        milk_present = 1'b1;
      end
    end
    $display("order: station 3 milk with empty reservoir, abort expected at cycle 13");
  endtask

  task automatic test_power_drop();
    logic [15:0] exp;
    req = 4'b0001;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = mk((c <= 8) ? 4'b0001 : 4'b0000, 1'b0, c == 8,
               c <= 4, c >= 5 && c <= 7, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL power_drop c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 7) power_on = 1'b0;
    end
    req      = 4'b0000;
    power_on = 1'b1;
    $display("order: station 0 power lost in 3rd brew cycle, abort at cycle 8, no grant while off");
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    req = 4'b0011;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = mk(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid_grant c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_async obs=%b exp=%b", obs, 16'h0000);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_held obs=%b exp=%b", obs, 16'h0000);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp = mk(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_mid_regrant obs=%b exp=%b", obs, exp);
    end
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_clean obs=%b exp=%b", obs, 16'h0000);
    end
    $display("order: station 1 dropped by reset in grind, station 0 regranted after release");
  endtask

  task automatic test_round_robin();
    logic [15:0] exp;
    int order [3] = '{0, 2, 0};
    int k;
    int o;
    logic [3:0] g;
    req = 4'b0101;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk);
      @(negedge clk);
      k = (c - 1) / 14;
      o = (c - 1) % 14;
      g = (o <= 12) ? (4'b0001 << order[k]) : 4'b0000;
      exp = mk(g, o == 12, 1'b0, o <= 3, o >= 4 && o <= 11, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL round_robin c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 41) req = 4'b0000;
    end
    $display("orders: stations 0,2 held, served 0 then 2 then 0");
  endtask

  task automatic test_req_drop();
    logic [15:0] exp;
    req = 4'b0010;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp = mk((c <= 13) ? 4'b0010 : 4'b0000, c == 13, 1'b0,
               c <= 4, c >= 5 && c <= 12, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL req_drop c=%0d obs=%b exp=%b", c, obs, exp);
      end
      if (c == 3) req = 4'b0000;
    end
    $display("order: station 1 request dropped in grind, still completes at cycle 13");
  endtask

  initial begin
    reset        = 1'b1;
    power_on     = 1'b1;
    milk_present = 1'b1;
    req          = 4'b0000;
    milk_sel     = 4'b0000;
    test_reset();
    test_basic();
    test_milk();
    test_milk_abort();
    test_power_drop();
    test_reset_mid();
    test_round_robin();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
